// File: rtl/sign_calc_pkg.sv
// Shared definitions for the sign-magnitude add/subtract controller.
//   MAG_W   : operand magnitude width
//   RES_W   : result magnitude width (one extra bit holds 15 + 15)
//   state_t : controller state encoding
package sign_calc_pkg;

    localparam int MAG_W = 4;
    localparam int RES_W = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EVAL = 3'd1,
        SUB1 = 3'd2,
        SUB2 = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/sign_calc_ctrl.sv
// Sign-magnitude add/subtract controller. Same-sign operands are summed with
// an inline adder; opposite-sign operands are handed to an external 4-bit
// subtractor, swapping minuend and subtrahend when the first pass borrows.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   start, op           : request (sampled in IDLE/DONE), 0 = A+B, 1 = A-B
//   a_sign, a_mag       : operand A (sign 1 = negative)
//   b_sign, b_mag       : operand B
//   sub_a, sub_b        : minuend/subtrahend to the external subtractor
//   sub_bin             : subtractor borrow-in, always 0
//   sub_diff, sub_bout  : subtractor difference and borrow-out (combinational)
//   busy, done          : busy in EVAL/SUB1/SUB2, done high for the DONE cycle
//   res_sign, res_mag   : registered sign-magnitude result
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// EVAL  | compare signs; same sign -> add, else present |A|-|B|
// SUB1  | |A|-|B| on subtractor; no borrow -> result, borrow -> swap
// SUB2  | |B|-|A| on subtractor; result takes the sign of effective B
// DONE  | result valid for one cycle; start here chains straight to EVAL
module sign_calc_ctrl
    import sign_calc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic [MAG_W-1:0] a_mag,
    input  logic [MAG_W-1:0] b_mag,
    output logic [MAG_W-1:0] sub_a,
    output logic [MAG_W-1:0] sub_b,
    output logic             sub_bin,
    input  logic [MAG_W-1:0] sub_diff,
    input  logic             sub_bout,
    output logic             busy,
    output logic             done,
    output logic             res_sign,
    output logic [RES_W-1:0] res_mag
);

    state_t           state, state_nxt;
    logic             a_sign_q, eb_q;
    logic [MAG_W-1:0] a_mag_q, b_mag_q;
    logic             load;
    logic             res_we;
    logic             res_sign_nxt;
    logic [RES_W-1:0] res_mag_nxt;
    logic [RES_W-1:0] mag_sum;

    assign sub_bin = 1'b0;
    assign mag_sum = RES_W'(a_mag_q) + RES_W'(b_mag_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            a_sign_q <= 1'b0;
            eb_q     <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            res_sign <= 1'b0;
            res_mag  <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_sign_q <= a_sign;
                eb_q     <= b_sign ^ op;
                a_mag_q  <= a_mag;
                b_mag_q  <= b_mag;
            end
            if (res_we) begin
                // A zero magnitude is always reported as +0.
                res_sign <= res_sign_nxt & (res_mag_nxt != '0);
                res_mag  <= res_mag_nxt;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        load         = 1'b0;
        res_we       = 1'b0;
        res_sign_nxt = a_sign_q;
        res_mag_nxt  = mag_sum;
        sub_a        = '0;
        sub_b        = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (a_sign_q == eb_q) begin
                    res_we       = 1'b1;
                    res_sign_nxt = a_sign_q;
                    res_mag_nxt  = mag_sum;
                    state_nxt    = DONE;
                end else begin
                    sub_a     = a_mag_q;
                    sub_b     = b_mag_q;
                    state_nxt = SUB1;
                end
            end
            SUB1: begin
                sub_a = a_mag_q;
                sub_b = b_mag_q;
                if (!sub_bout) begin
                    res_we       = 1'b1;
                    res_sign_nxt = a_sign_q;
                    res_mag_nxt  = {1'b0, sub_diff};
                    state_nxt    = DONE;
                end else begin
                    state_nxt = SUB2;
                end
            end
            SUB2: begin
                // |B| > |A| here, so the reversed subtraction cannot borrow.
                sub_a        = b_mag_q;
                sub_b        = a_mag_q;
                res_we       = 1'b1;
                res_sign_nxt = eb_q;
                res_mag_nxt  = {1'b0, sub_diff};
                state_nxt    = DONE;
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = EVAL;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == EVAL) || (state == SUB1) || (state == SUB2);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sign_calc_ctrl.sv
// Directed bench for sign_calc_ctrl. The external 4-bit subtractor is modelled
// here as a plain combinational subtract with borrow-out.
module tb_sign_calc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic       a_sign = 1'b0;
    logic       b_sign = 1'b0;
    logic [3:0] a_mag = '0;
    logic [3:0] b_mag = '0;
    logic [3:0] sub_a, sub_b, sub_diff;
    logic       sub_bin, sub_bout;
    logic       busy, done, res_sign;
    logic [4:0] res_mag;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] sa_tr [1:4];
    logic [3:0] sb_tr [1:4];

    always #5 clk = ~clk;

    assign sub_diff = sub_a - sub_b;
    assign sub_bout = (sub_a < sub_b);

    sign_calc_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a_sign   (a_sign),
        .b_sign   (b_sign),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .sub_a    (sub_a),
        .sub_b    (sub_b),
        .sub_bin  (sub_bin),
        .sub_diff (sub_diff),
        .sub_bout (sub_bout),
        .busy     (busy),
        .done     (done),
        .res_sign (res_sign),
        .res_mag  (res_mag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, scramble the operand inputs after the sampling edge,
    // and wait for done. Returns at done (1 time unit after its edge).
    task automatic do_op(input string tag, input logic as, input logic [3:0] am,
                         input logic o, input logic bs, input logic [3:0] bm,
                         input int exp_lat, input logic exp_sign, input logic [4:0] exp_mag);
        int lat;
        a_sign = as; a_mag = am; op = o; b_sign = bs; b_mag = bm; start = 1'b1;
        tick();
        start = 1'b0;
        a_sign = ~as; a_mag = ~am; op = ~o; b_sign = bs; b_mag = ~bm;
        lat = 1;
        for (int k = 1; k <= 4; k++) begin sa_tr[k] = 'x; sb_tr[k] = 'x; end
        while (!done && lat < 8) begin
            sa_tr[lat] = sub_a;
            sb_tr[lat] = sub_b;
            chk({tag, "_busy"}, busy, 1);
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_sign"}, res_sign, exp_sign);
        chk({tag, "_mag"}, res_mag, exp_mag);
        chk({tag, "_busy_at_done"}, busy, 0);
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res_sign", res_sign, 0);
        chk("rst_res_mag", res_mag, 0);
        chk("rst_sub_a", sub_a, 0);
        chk("rst_sub_b", sub_b, 0);
        chk("sub_bin", sub_bin, 0);
        rst = 1'b1;
        #2;

        // +3 + +5 = +8, first start right after reset release
        do_op("add_same", 0, 4'd3, 0, 0, 4'd5, 2, 0, 5'd8);
        chk("add_same_sub_a_eval", sa_tr[1], 0);
        chk("add_same_sub_b_eval", sb_tr[1], 0);
        tick();
        chk("idle_after_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_res_held", res_mag, 5'd8);

        // +7 - +2 = +5, no swap
        do_op("sub_noswap", 0, 4'd7, 1, 0, 4'd2, 3, 0, 5'd5);
        chk("noswap_sub_a_eval", sa_tr[1], 4'd7);
        chk("noswap_sub_b_eval", sb_tr[1], 4'd2);
        chk("noswap_sub_a_sub1", sa_tr[2], 4'd7);
        chk("noswap_sub_b_sub1", sb_tr[2], 4'd2);
        chk("noswap_sub_a_done", sub_a, 0);

        // +2 - +7 = -5 via swap; started straight from DONE
        do_op("sub_swap", 0, 4'd2, 1, 0, 4'd7, 4, 1, 5'd5);
        chk("swap_sub_a_sub1", sa_tr[2], 4'd2);
        chk("swap_sub_b_sub1", sb_tr[2], 4'd7);
        chk("swap_sub_a_sub2", sa_tr[3], 4'd7);
        chk("swap_sub_b_sub2", sb_tr[3], 4'd2);

        do_op("max_mag", 1, 4'd15, 0, 1, 4'd15, 2, 1, 5'd30);
        do_op("zero_sub", 0, 4'd6, 1, 0, 4'd6, 3, 0, 5'd0);
        do_op("neg_zero", 1, 4'd4, 0, 0, 4'd4, 3, 0, 5'd0);
        do_op("neg_minus_neg", 1, 4'd9, 1, 1, 4'd3, 3, 1, 5'd6);
        do_op("neg_plus_pos_swap", 1, 4'd1, 0, 0, 4'd12, 4, 0, 5'd11);
        tick();

        // Reset asserted during SUB1 aborts with no done
        a_sign = 0; a_mag = 4'd2; op = 1; b_sign = 0; b_mag = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("abort_in_sub1_busy", busy, 1);
        chk("abort_in_sub1_sub_b", sub_b, 4'd7);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_res_sign", res_sign, 0);
        chk("abort_res_mag", res_mag, 0);
        chk("abort_sub_a", sub_a, 0);
        chk("abort_sub_b", sub_b, 0);
        tick();
        chk("abort_no_done", done, 0);
        #2 rst = 1'b1;
        #1;
        do_op("after_abort", 0, 4'd9, 0, 0, 4'd4, 2, 0, 5'd13);
        tick();

        // start during SUB1 is ignored; result uses the original operands
        a_sign = 0; a_mag = 4'd7; op = 1; b_sign = 0; b_mag = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a_sign = 1; a_mag = 4'd15; op = 0; b_sign = 1; b_mag = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ignore_done", done, 1);
        chk("ignore_sign", res_sign, 0);
        chk("ignore_mag", res_mag, 5'd5);
        tick();
        chk("ignore_back_idle_done", done, 0);
        chk("ignore_back_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sign_calc_ctrl.md
SIGN_CALC_CTRL -- requirements
Module: sign_calc_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 start  input  1  operation request; sampled only when the controller is idle.
REQ-005 op  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-006 a_sign, b_sign  input  1 each  operand signs; 1 = negative.
REQ-007 a_mag, b_mag  input  4 each  unsigned operand magnitudes, 0..15.
REQ-008 sub_a, sub_b  output  4 each  minuend and subtrahend driven to the downstream 4-bit subtractor.
REQ-009 sub_bin  output  1  borrow-in to the subtractor; tied to constant 0.
REQ-010 sub_diff  input  4  difference returned by the subtractor; combinational, valid in the same cycle.
REQ-011 sub_bout  input  1  borrow-out returned by the subtractor.
REQ-012 busy  output  1  high when state is EVAL, SUB1 or SUB2.
REQ-013 done  output  1  one-cycle pulse, registered, marking that the result is valid.
REQ-014 res_sign, res_mag  output  1 and 5  sign-magnitude result, registered, held until the next accepted start.

Function
REQ-015 FSM states SHALL be IDLE, EVAL, SUB1, SUB2, DONE.
- start is accepted in IDLE or DONE.
- start is ignored in all other states.
REQ-016 On an accepted start, the block SHALL do the following on the same clock edge:
- latch a_sign, a_mag and b_mag;
- latch effective sign eb = b_sign XOR op;
- go to EVAL.
REQ-017 In EVAL with a_sign == eb, the block SHALL:
- set res_mag = a_mag + b_mag, zero-extended to 5 bits;
- set res_sign = a_sign;
- go to DONE.
REQ-018 In EVAL with a_sign != eb, the block SHALL drive sub_a = a_mag and sub_b = b_mag, then go to SUB1.
REQ-019 In SUB1, sub_a = a_mag and sub_b = b_mag SHALL remain driven.
- If sub_bout == 0: res_mag = {0, sub_diff}, res_sign = a_sign, go to DONE.
- If sub_bout == 1: go to SUB2.
REQ-020 In SUB2, the block SHALL drive sub_a = b_mag and sub_b = a_mag, set res_mag = {0, sub_diff} and res_sign = eb, then go to DONE.
REQ-021 In IDLE, EVAL (same-sign case) and DONE, sub_a and sub_b SHALL be driven to 0.
REQ-022 A result with res_mag == 0 SHALL have res_sign = 0 (no negative zero).
REQ-023 done SHALL be high exactly for the cycle in DONE.
- DONE returns to IDLE, or to EVAL if start is high.
REQ-024 Latency from the start-sampling edge to done high SHALL be 2 edges for same-sign operands, 3 for different signs without a swap, and 4 with a swap.
REQ-025 Magnitude overflow cannot occur: the maximum result, 15+15 = 30, fits in 5 bits, and the block SHALL have no overflow flag.
REQ-026 Operand inputs SHALL NOT affect an operation in progress; only the latched values are used.

Reset
REQ-027 While rst is low, the block SHALL hold the following, regardless of clk:
- state = IDLE;
- busy = 0 and done = 0;
- res_sign = 0 and res_mag = 0;
- all latched operands = 0, so sub_a = 0 and sub_b = 0.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-029 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-030 The FSM state encoding and the widths MAG_W = 4 and RES_W = 5 SHALL live in the shared package sign_calc_pkg.
REQ-031 The block SHALL contain no sub-module.
- The subtractor is external and connected through the sub_* ports.
- The same-sign magnitude add is an inline 5-bit adder.

Verification
REQ-032 Same-sign add: +3 op=0 +5 -> res +8 (01000); done 2 edges after start.
REQ-033 Subtract without swap: +7 op=1 +2 -> SUB1 with bout=0 -> res +5; done after 3 edges; sub_a=7 and sub_b=2 during EVAL and SUB1.
REQ-034 Subtract with swap: +2 op=1 +7 -> bout=1 -> SUB2 with sub_a=7, sub_b=2 -> res -5; done after 4 edges.
REQ-035 Maximum magnitude: -15 op=0 -15 -> res_sign 1, res_mag 11110.
REQ-036 Zero result: +6 op=1 +6 -> res_mag 0, res_sign 0.
- -4 op=0 +4 also gives res_sign 0.
REQ-037 Abort and ignore rules:
- rst pulsed low during SUB1 -> immediate IDLE, all outputs 0, no done.
- start pulsed during SUB1 -> ignored; the result still matches the original operands.
